// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches from a combinational imem and buffers {instr, pc} in a FIFO.
// Optional misaligned-redirect fault detection is enabled by defining IF_ALIGN_CHECK_EN.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [31:0] pc_q, pc_d;
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        fault_q, fault_d;
    logic [31:0] memInstr_q [DEPTH];
    logic [31:0] memPc_q    [DEPTH];

    logic        emptyS, fullS, popS, pushS;
    logic [31:0] targetPc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        emptyS = (wrPtr_q == rdPtr_q);
        fullS  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        popS   = !emptyS && instr_ready;
        pushS  = !redirect_valid && !fault_q && (!fullS || popS);
    end

`ifdef IF_ALIGN_CHECK_EN
    always_comb begin
        targetPc = redirect_pc;
        fault_d  = fault_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
    end
`else
    always_comb begin
        targetPc = redirect_pc & ~32'h3;
        fault_d  = 1'b0;
    end
`endif

    // A redirect flushes everything, including an entry popped in the same cycle.
    always_comb begin
        pc_d    = pc_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (redirect_valid) begin
            pc_d    = targetPc;
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (popS) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (pushS) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
                pc_d    = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                memInstr_q[i] <= '0;
                memPc_q[i]    <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            fault_q <= fault_d;
            if (pushS) begin
                memInstr_q[wrPtr_q[AW-1:0]] <= imem_rdata;
                memPc_q[wrPtr_q[AW-1:0]]    <= pc_q;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = !emptyS;
    assign instr       = memInstr_q[rdPtr_q[AW-1:0]];
    assign instr_pc    = memPc_q[rdPtr_q[AW-1:0]];
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios followed by random traffic, checked against a queue model.
// Follows IF_ALIGN_CHECK_EN the same way the design does.
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [63:0] modelQ[$];
    logic [31:0] modelPc;
    logic        modelFault;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hBEEF, addr[31:16] ^ 16'h1234};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("imem_addr", imem_addr, modelPc);
        checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, (modelQ.size() > 0)});
        checkOutput("fetch_fault", {31'b0, fetch_fault}, {31'b0, modelFault});
        if (modelQ.size() > 0) begin
            checkOutput("instr", instr, modelQ[0][63:32]);
            checkOutput("instr_pc", instr_pc, modelQ[0][31:0]);
        end
    endtask

    // Drives one cycle of inputs, advances the model, then checks after the edge.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        reset          = rst;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst) begin
            modelQ.delete();
            modelPc    = RESET_PC;
            modelFault = 1'b0;
        end else if (rv) begin
            modelQ.delete();
`ifdef IF_ALIGN_CHECK_EN
            modelPc = rpc;
            if (rpc % 4 != 0) modelFault = 1'b1;
`else
            modelPc = rpc - (rpc % 4);
`endif
        end else begin
            if (modelQ.size() > 0 && rdy) void'(modelQ.pop_front());
            if (!modelFault && modelQ.size() < DEPTH) begin
                modelQ.push_back({memWord(modelPc), modelPc});
                modelPc = modelPc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        modelPc        = RESET_PC;
        modelFault     = 1'b0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);

        $display("[TB] reset release, sequential fetch");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("seq_valid", {31'b0, instr_valid}, 32'd1);
            checkOutput("seq_pc", instr_pc, 32'(i * 4));
            checkOutput("seq_instr", instr, memWord(32'(i * 4)));
            applyStimulus(0, 1, 0, 0);
        end

        $display("[TB] back-pressure then drain");
        applyStimulus(1, 1, 0, 0);
        checkOutput("midrst_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("bp_addr", imem_addr, 32'd16);
        checkOutput("bp_head", instr_pc, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("drain_valid", {31'b0, instr_valid}, 32'd1);
            checkOutput("drain_pc", instr_pc, 32'(i * 4));
            applyStimulus(0, 1, 0, 0);
            if (i == 0) checkOutput("full_pushpop_addr", imem_addr, 32'd20);
        end

        $display("[TB] redirect with queued entries");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h40);
        checkOutput("redir_bubble", {31'b0, instr_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h40);
        applyStimulus(0, 1, 0, 0);
        checkOutput("redir_target", instr_pc, 32'h40);
        applyStimulus(0, 1, 0, 0);
        checkOutput("redir_next", instr_pc, 32'h44);

        $display("[TB] pc wrap");
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_head", instr_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_next", instr_pc, 32'h0);

        $display("[TB] misaligned redirect");
        applyStimulus(0, 1, 1, 32'h42);
`ifdef IF_ALIGN_CHECK_EN
        checkOutput("fault_set", {31'b0, fetch_fault}, 32'd1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("fault_sticky", {31'b0, fetch_fault}, 32'd1);
        checkOutput("fault_novalid", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("fault_clear", {31'b0, fetch_fault}, 32'd0);
`else
        checkOutput("align_addr", imem_addr, 32'h40);
        applyStimulus(0, 1, 0, 0);
        checkOutput("align_pc", instr_pc, 32'h40);
        checkOutput("align_nofault", {31'b0, fetch_fault}, 32'd0);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic        rst, rdy, rv;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            applyStimulus(rst, rdy, rv, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
